// File: rtl/pll_reconfig_pkg.sv
// Shared constants for the capture-PLL reconfiguration controller:
// mgmt register map, counter-data fields, CSR map and FSM states.
package pll_reconfig_pkg;

    // Reconfig core mgmt register addresses
    localparam logic [5:0] MGMT_MODE  = 6'h00;
    localparam logic [5:0] MGMT_START = 6'h02;
    localparam logic [5:0] MGMT_N     = 6'h03;
    localparam logic [5:0] MGMT_M     = 6'h04;
    localparam logic [5:0] MGMT_C     = 6'h05;

    // Divider / counter-data fields
    localparam int DIV_W     = 18;
    localparam int C_IDX_LSB = 18;
    localparam int C_IDX_W   = 5;

    // CSR word addresses
    localparam logic [2:0] CSR_CTRL    = 3'd0;
    localparam logic [2:0] CSR_STATUS  = 3'd1;
    localparam logic [2:0] CSR_M_DIV   = 3'd2;
    localparam logic [2:0] CSR_N_DIV   = 3'd3;
    localparam logic [2:0] CSR_C_DIV   = 3'd4;
    localparam logic [2:0] CSR_TIMEOUT = 3'd5;

    // Sequencer states
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WR_MODE   = 3'd1;
    localparam logic [2:0] ST_WR_N      = 3'd2;
    localparam logic [2:0] ST_WR_M      = 3'd3;
    localparam logic [2:0] ST_WR_C      = 3'd4;
    localparam logic [2:0] ST_WR_START  = 3'd5;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd6;

    // Counter word: index k above the 18-bit counter data
    function automatic logic [31:0] c_word(
        input logic [C_IDX_W-1:0] k,
        input logic [DIV_W-1:0]   d
    );
        return {9'd0, k, d};
    endfunction

endpackage

// File: rtl/pll_mgmt_writer.sv
// Single Avalon-MM write handshake toward the PLL reconfig core.
// Ports: req/req_address/req_writedata in, ack out (acceptance
// pulse), mgmt_address/mgmt_write/mgmt_writedata out,
// mgmt_waitrequest in. clk / rst_n (sync, active-low).
module pll_mgmt_writer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [5:0]  req_address,
    input  logic [31:0] req_writedata,
    output logic        ack,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest
);

    assign ack = mgmt_write && !mgmt_waitrequest;

    // Address/data are latched at issue and held until acceptance;
    // a request seen during the acceptance cycle is not reissued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
        end else if (mgmt_write) begin
            if (!mgmt_waitrequest)
                mgmt_write <= 1'b0;
        end else if (req) begin
            mgmt_write     <= 1'b1;
            mgmt_address   <= req_address;
            mgmt_writedata <= req_writedata;
        end
    end

endmodule

// File: rtl/pll_capture_reconfig_ctrl.sv
// Capture-PLL reconfiguration initiator: CSR block for HPS plus a
// sequencer that programs the reconfig core and waits for relock.
// Ports: csr_* (HPS CSR slave), mgmt_* (reconfig core master),
// pll_locked (async), irq (done|err). clk / rst_n (sync, active-low).
module pll_capture_reconfig_ctrl
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_C        = 2,
    parameter int LOCK_TIMEOUT = 1_000_000,
    parameter int TO_W         = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  csr_address,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    input  logic        csr_read,
    output logic [31:0] csr_readdata,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        irq
);

    localparam int CI_W = (NUM_C > 1) ? $clog2(NUM_C) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST = C_IDX_W'(NUM_C - 1);
    localparam logic [C_IDX_W-1:0] C_NUM  = C_IDX_W'(NUM_C);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(LOCK_TIMEOUT);
    localparam logic [TO_W-1:0] BLANK  = TO_W'(16);

    logic [2:0]         state;
    logic [DIV_W-1:0]   m_reg;
    logic [DIV_W-1:0]   n_reg;
    logic [DIV_W-1:0]   c_reg [NUM_C];
    logic [C_IDX_W-1:0] c_idx;
    logic [TO_W-1:0]    count;
    logic [TO_W-1:0]    count_inc;
    logic [TO_W-1:0]    to_reg;
    logic               done;
    logic               err;
    logic               lk_meta;
    logic               locked_sync;
    logic               busy;
    logic               wr_req;
    logic               wr_ack;
    logic [5:0]         wr_addr;
    logic [31:0]        wr_data;
    logic [31:0]        rdata;
    logic [C_IDX_W-1:0] wk;
    logic               start_req;
    logic               unused_wdata;

    assign busy      = (state != ST_IDLE);
    assign irq       = done | err;
    assign wr_req    = busy && (state != ST_WAIT_LOCK);
    assign count_inc = count + TO_W'(1);
    assign wk        = csr_writedata[C_IDX_LSB +: C_IDX_W];
    assign start_req = csr_write && (csr_address == CSR_CTRL)
                       && csr_writedata[0];
    assign unused_wdata = ^csr_writedata[31:23];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lk_meta     <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            lk_meta     <= pll_locked;
            locked_sync <= lk_meta;
        end
    end

    always_comb begin
        wr_addr = MGMT_MODE;
        wr_data = '0;
        case (state)
            ST_WR_N: begin
                wr_addr = MGMT_N;
                wr_data = {14'd0, n_reg};
            end
            ST_WR_M: begin
                wr_addr = MGMT_M;
                wr_data = {14'd0, m_reg};
            end
            ST_WR_C: begin
                wr_addr = MGMT_C;
                wr_data = c_word(c_idx, c_reg[c_idx[CI_W-1:0]]);
            end
            ST_WR_START: begin
                wr_addr = MGMT_START;
                wr_data = 32'd1;
            end
            default: ;
        endcase
    end

    pll_mgmt_writer u_writer (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (wr_req),
        .req_address      (wr_addr),
        .req_writedata    (wr_data),
        .ack              (wr_ack),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            m_reg  <= '0;
            n_reg  <= '0;
            for (int i = 0; i < NUM_C; i++)
                c_reg[i] <= '0;
            c_idx  <= '0;
            count  <= '0;
            to_reg <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (csr_write && !busy) begin
                if (csr_address == CSR_M_DIV)
                    m_reg <= csr_writedata[DIV_W-1:0];
                if (csr_address == CSR_N_DIV)
                    n_reg <= csr_writedata[DIV_W-1:0];
                if (csr_address == CSR_C_DIV && wk < C_NUM)
                    c_reg[wk[CI_W-1:0]] <= csr_writedata[DIV_W-1:0];
            end
            // W1C first so a same-cycle set from the FSM wins
            if (csr_write && csr_address == CSR_STATUS) begin
                if (csr_writedata[1]) done <= 1'b0;
                if (csr_writedata[2]) err  <= 1'b0;
            end
            case (state)
                ST_IDLE: if (start_req) begin
                    state <= ST_WR_MODE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    c_idx <= '0;
                end
                ST_WR_MODE: if (wr_ack) state <= ST_WR_N;
                ST_WR_N:    if (wr_ack) state <= ST_WR_M;
                ST_WR_M:    if (wr_ack) state <= ST_WR_C;
                ST_WR_C: if (wr_ack) begin
                    if (c_idx == C_LAST)
                        state <= ST_WR_START;
                    else
                        c_idx <= c_idx + C_IDX_W'(1);
                end
                ST_WR_START: if (wr_ack) begin
                    state <= ST_WAIT_LOCK;
                    count <= '0;
                end
                ST_WAIT_LOCK: begin
                    // count_inc is cycles elapsed since acceptance;
                    // lock is blanked for the first 16 of them
                    if (locked_sync && count >= BLANK) begin
                        done   <= 1'b1;
                        err    <= 1'b0;
                        to_reg <= count_inc;
                        state  <= ST_IDLE;
                    end else if (count_inc == TO_MAX) begin
                        err    <= 1'b1;
                        to_reg <= TO_MAX;
                        state  <= ST_IDLE;
                    end else begin
                        count <= count_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (csr_address)
            CSR_STATUS:  rdata = {28'd0, locked_sync, err, done, busy};
            CSR_M_DIV:   rdata = {14'd0, m_reg};
            CSR_N_DIV:   rdata = {14'd0, n_reg};
            CSR_TIMEOUT: rdata = 32'(to_reg);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            csr_readdata <= '0;
        else if (csr_read)
            csr_readdata <= rdata;
        else
            csr_readdata <= '0;
    end

endmodule

// File: tb/tb_pll_capture_reconfig_ctrl.sv
// Testbench for pll_capture_reconfig_ctrl: directed sequences with a
// reference model of the mgmt write stream and relock timing.
module tb_pll_capture_reconfig_ctrl;

    localparam int NUM_C = 2;
    localparam int LT    = 120;
    localparam int TO_W  = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  csr_address = '0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic        csr_read = 1'b0;
    logic [31:0] csr_readdata;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;
    logic        irq;

    pll_capture_reconfig_ctrl #(
        .NUM_C(NUM_C), .LOCK_TIMEOUT(LT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_address(csr_address), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_read(csr_read),
        .csr_readdata(csr_readdata),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [5:0] a; logic [31:0] d; } wr_t;
    wr_t expq[$];
    logic [17:0] mdl_m = '0;
    logic [17:0] mdl_n = '0;
    logic [17:0] mdl_c [NUM_C];

    task automatic load_expected();
        expq.push_back(wr_t'{a: 6'h00, d: 32'd0});
        expq.push_back(wr_t'{a: 6'h03, d: 32'(mdl_n)});
        expq.push_back(wr_t'{a: 6'h04, d: 32'(mdl_m)});
        for (int k = 0; k < NUM_C; k++)
            expq.push_back(wr_t'{a: 6'h05,
                d: (32'(k) << 18) | 32'(mdl_c[k])});
        expq.push_back(wr_t'{a: 6'h02, d: 32'd1});
    endtask

    // ---------------- mgmt slave + compare ----------------
    int   stall_n = 0;
    int   hold = 0;
    int   acc_cnt = 0;
    int   start_edge = -1;
    logic w_nx;
    logic prev_w = 1'b0;
    logic prev_acc = 1'b0;
    logic [5:0]  prev_a = '0;
    logic [31:0] prev_d = '0;
    wr_t  e;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 0;
            mgmt_waitrequest = 1'b0;
            prev_w = 1'b0;
            prev_acc = 1'b0;
        end else begin
            if (prev_acc)
                chk("write_drop", 32'(mgmt_write), 32'd0);
            if (prev_w && !prev_acc && mgmt_write) begin
                chk("addr_stable", 32'(mgmt_address), 32'(prev_a));
                chk("data_stable", mgmt_writedata, prev_d);
            end
            w_nx = 1'b0;
            if (mgmt_write && hold < stall_n) begin
                w_nx = 1'b1;
                hold++;
            end else begin
                hold = 0;
            end
            mgmt_waitrequest = w_nx;
            prev_acc = mgmt_write && !w_nx;
            if (prev_acc) begin
                acc_cnt++;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h want none",
                             mgmt_address);
                end else begin
                    e = expq.pop_front();
                    chk("wr_addr", 32'(mgmt_address), 32'(e.a));
                    chk("wr_data", mgmt_writedata, e.d);
                end
                if (mgmt_address == 6'h02)
                    start_edge = cyc + 1;
            end
            prev_w = mgmt_write;
            prev_a = mgmt_address;
            prev_d = mgmt_writedata;
        end
    end

    // ---------------- CSR helpers ----------------
    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_address = a;
        csr_writedata = d;
        csr_write = 1'b1;
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        csr_address = a;
        csr_read = 1'b1;
        @(negedge clk);
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic set_m(input logic [17:0] v);
        csr_wr(3'd2, 32'(v));
        mdl_m = v;
    endtask

    task automatic set_n(input logic [17:0] v);
        csr_wr(3'd3, 32'(v));
        mdl_n = v;
    endtask

    task automatic set_c(input int k, input logic [17:0] v);
        csr_wr(3'd4, (32'(k) << 18) | 32'(v));
        if (k < NUM_C) mdl_c[k] = v;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // lock_after: -1 never, -2 already high, else raise pll_locked
    // after that many cycles past WR_START acceptance
    task automatic run_seq(input int lock_after, input bit poke,
                           output int kexp);
        int a0, t;
        bit exp_done;
        logic [31:0] d;
        load_expected();
        a0 = acc_cnt;
        start_edge = -1;
        csr_wr(3'd0, 32'd1);
        if (poke) begin
            csr_wr(3'd0, 32'd1);
            csr_wr(3'd2, 32'h1234);
        end
        t = 0;
        while (start_edge < 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (start_edge < 0) begin
            total++;
            bad++;
            $display("FAIL start_accept: got none want WR_START");
            kexp = 0;
            return;
        end
        if (lock_after == -2) begin
            kexp = 17;
            exp_done = 1'b1;
        end else if (lock_after == -1) begin
            kexp = LT;
            exp_done = 1'b0;
        end else begin
            kexp = (lock_after + 3 > 17) ? lock_after + 3 : 17;
            exp_done = (kexp <= LT);
            if (!exp_done) kexp = LT;
        end
        if (lock_after >= 0 && lock_after < kexp - 1) begin
            wait_cyc(start_edge + lock_after);
            pll_locked = 1'b1;
        end
        wait_cyc(start_edge + kexp - 1);
        chk("irq_before_end", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_at_end", 32'(irq), 32'd1);
        csr_rd(3'd1, d);
        chk("status_end", d,
            {28'd0, pll_locked, !exp_done, exp_done, 1'b0});
        csr_rd(3'd5, d);
        chk("timeout_reg", d, 32'(kexp));
        chk("acc_count", 32'(acc_cnt - a0), 32'(NUM_C + 4));
        chk("queue_empty", 32'(expq.size()), 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] d;
        int k;
        int a1;
        int t;
        for (int i = 0; i < NUM_C; i++) mdl_c[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_mgmt_write", 32'(mgmt_write), 32'd0);
        chk("rst_mgmt_addr", 32'(mgmt_address), 32'd0);
        chk("rst_mgmt_data", mgmt_writedata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_readdata", csr_readdata, 32'd0);
        rst_n = 1'b1;
        csr_rd(3'd1, d);
        chk("rst_status", d, 32'd0);
        csr_rd(3'd2, d);
        chk("rst_m_div", d, 32'd0);

        // 1: basic sequence, literal write stream and timing
        set_m(18'h00505);
        set_n(18'h10000);
        set_c(0, 18'h10000);
        set_c(1, 18'h00107);
        set_c(2, 18'h3ffff);
        chk("lit_c0_word", (32'd0 << 18) | 32'(mdl_c[0]), 32'h0001_0000);
        chk("lit_c1_word", (32'd1 << 18) | 32'(mdl_c[1]), 32'h0004_0107);
        run_seq(100, 1'b0, k);
        chk("lit_t1_kexp", 32'(k), 32'd103);
        csr_wr(3'd1, 32'h2);
        csr_rd(3'd1, d);
        chk("w1c_done", d, 32'h8);
        chk("irq_after_w1c", 32'(irq), 32'd0);
        pll_locked = 1'b0;
        repeat (4) @(negedge clk);

        // 2: 7-cycle waitrequest on every write
        stall_n = 7;
        run_seq(30, 1'b0, k);
        stall_n = 0;
        pll_locked = 1'b0;
        repeat (4) @(negedge clk);

        // 3: no lock -> timeout, then W1C err
        run_seq(-1, 1'b0, k);
        chk("lit_t3_kexp", 32'(k), 32'd120);
        csr_wr(3'd1, 32'h4);
        csr_rd(3'd1, d);
        chk("w1c_err", d, 32'd0);
        chk("irq_after_err_clr", 32'(irq), 32'd0);

        // 4: START and M_DIV while busy are ignored
        run_seq(20, 1'b1, k);
        a1 = acc_cnt;
        repeat (30) @(negedge clk);
        chk("no_second_seq", 32'(acc_cnt - a1), 32'd0);
        csr_rd(3'd2, d);
        chk("m_div_kept", d, 32'(mdl_m));
        pll_locked = 1'b0;
        repeat (4) @(negedge clk);

        // 5: reset during WR_C
        stall_n = 7;
        load_expected();
        csr_wr(3'd0, 32'd1);
        t = 0;
        while (!(mgmt_write && mgmt_address == 6'h05) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("reached_wr_c", 32'(mgmt_address), 32'h5);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_write", 32'(mgmt_write), 32'd0);
        stall_n = 0;
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        mdl_m = '0;
        mdl_n = '0;
        for (int i = 0; i < NUM_C; i++) mdl_c[i] = '0;
        csr_rd(3'd1, d);
        chk("status_after_rst", d, 32'd0);
        csr_rd(3'd2, d);
        chk("m_div_after_rst", d, 32'd0);
        set_m(18'h20a0b);
        set_n(18'h00303);
        set_c(1, 18'h2aa55);
        pll_locked = 1'b1;
        repeat (4) @(negedge clk);
        run_seq(-2, 1'b0, k);
        chk("lit_blank_kexp", 32'(k), 32'd17);
        pll_locked = 1'b0;
        repeat (4) @(negedge clk);

        // 6: lock on the timeout cycle wins; one cycle later loses
        run_seq(117, 1'b0, k);
        pll_locked = 1'b0;
        repeat (4) @(negedge clk);
        run_seq(118, 1'b0, k);
        pll_locked = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
